// File: rtl/dma_pkg.sv
// Shared definitions for the floppy DMA channel.
// Holds the sequencer state encoding, the transfer-type codes stored in the
// mode register, and the fixed controller-wide I/O port addresses.
package dma_pkg;

  // Sequencer states. One byte moves per pass through HOLD..S3.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_S1   = 3'd2,
    ST_S2   = 3'd3,
    ST_S3   = 3'd4
  } dma_state_e;

  // Transfer type, mode register bits [3:2]. 2'b11 is unused and moves no data.
  localparam logic [1:0] XFER_VERIFY  = 2'b00;
  localparam logic [1:0] XFER_DEV2MEM = 2'b01;
  localparam logic [1:0] XFER_MEM2DEV = 2'b10;

  // Channel number carried in bits [1:0] of mask and mode writes.
  localparam logic [1:0] CHAN_SEL = 2'd2;

  // Controller-wide ports, shared by all channels.
  localparam logic [19:0] STATUS_PORT = 20'h008;
  localparam logic [19:0] MASK_PORT   = 20'h00A;
  localparam logic [19:0] MODE_PORT   = 20'h00B;
  localparam logic [19:0] CLR_FF_PORT = 20'h00C;

endpackage

// File: rtl/dma_chan_regs.sv
// CPU-visible register file of the floppy DMA channel.
// Purpose: decodes CPU reads/writes (only while aen=0), keeps the base and
// current address/count copies, page, mask, mode, byte-pointer flip-flop and
// terminal-count flag, and applies the per-byte update computed by the top.
// Optional feature: DMA_AUTOINIT_EN makes mode bit 4 (autoinit) take effect;
// without it the bit is accepted but always reads as 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   a_in, d_in            CPU address / write data
//   ior_n, iow_n, aen     CPU strobes; aen=1 disables decoding
//   drq                   device request, reflected in the status byte
//   busy                  sequencer not idle; CPU writes are dropped
//   upd                   apply end-of-byte update this clock
//   reload                take current address/count from base copies
//   set_tc, set_mask      raise tc_flag / mask as part of the update
//   nxt_addr, nxt_cnt     incremented address / decremented count
//   d_out, d_oe           read data, held while ior_n stays low
//   cur_addr, cur_cnt     current address / count
//   page, mask            page bits 19:16, channel mask
//   xfer_type, autoinit   mode fields
// Every CPU access acts once, at the first clock its strobe is seen low;
// read data is captured there and held until the strobe rises.
module dma_chan_regs
  import dma_pkg::*;
#(
  parameter logic [19:0] CH_ADDR_PORT = 20'h004,
  parameter logic [19:0] CH_CNT_PORT  = 20'h005,
  parameter logic [19:0] CH_PAGE_PORT = 20'h081
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] a_in,
  input  logic [7:0]  d_in,
  input  logic        ior_n,
  input  logic        iow_n,
  input  logic        aen,
  input  logic        drq,
  input  logic        busy,
  input  logic        upd,
  input  logic        reload,
  input  logic        set_tc,
  input  logic        set_mask,
  input  logic [15:0] nxt_addr,
  input  logic [15:0] nxt_cnt,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic [15:0] cur_addr,
  output logic [15:0] cur_cnt,
  output logic [3:0]  page,
  output logic        mask,
  output logic [1:0]  xfer_type,
  output logic        autoinit
);

  logic [15:0] base_addr;
  logic [15:0] base_cnt;
  logic        byte_ff;
  logic        tc_flag;
  logic        ior_q;
  logic        iow_q;
  logic        rd_start;
  logic        wr_start;
  logic        rd_hit;
  logic        rd_two_byte;
  logic [7:0]  rd_data;

  assign rd_start = !aen && !ior_n && ior_q;
  assign wr_start = !aen && !iow_n && iow_q && !busy;

  always_comb begin
    rd_data     = 8'h00;
    rd_hit      = 1'b1;
    rd_two_byte = 1'b0;
    if (a_in == CH_ADDR_PORT) begin
      rd_data     = byte_ff ? cur_addr[15:8] : cur_addr[7:0];
      rd_two_byte = 1'b1;
    end else if (a_in == CH_CNT_PORT) begin
      rd_data     = byte_ff ? cur_cnt[15:8] : cur_cnt[7:0];
      rd_two_byte = 1'b1;
    end else if (a_in == CH_PAGE_PORT) begin
      rd_data = {4'h0, page};
    end else if (a_in == STATUS_PORT) begin
      rd_data = {1'b0, drq, 3'b000, tc_flag, 2'b00};
    end else begin
      rd_hit = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ior_q     <= 1'b1;
      iow_q     <= 1'b1;
      d_out     <= 8'h00;
      d_oe      <= 1'b0;
      base_addr <= 16'h0000;
      base_cnt  <= 16'h0000;
      cur_addr  <= 16'h0000;
      cur_cnt   <= 16'h0000;
      page      <= 4'h0;
      mask      <= 1'b1;
      xfer_type <= XFER_VERIFY;
      autoinit  <= 1'b0;
      byte_ff   <= 1'b0;
      tc_flag   <= 1'b0;
    end else begin
      ior_q <= ior_n;
      iow_q <= iow_n;

      // Reads: capture once, hold until the strobe is released.
      if (rd_start && rd_hit) begin
        d_out <= rd_data;
        d_oe  <= 1'b1;
      end else if (ior_n) begin
        d_oe <= 1'b0;
      end
      if (rd_start && rd_two_byte) byte_ff <= ~byte_ff;
      if (rd_start && (a_in == STATUS_PORT)) tc_flag <= 1'b0;

      // Writes: both copies load together, byte chosen by the flip-flop.
      if (wr_start) begin
        if (a_in == CH_ADDR_PORT) begin
          if (byte_ff) begin
            base_addr[15:8] <= d_in;
            cur_addr[15:8]  <= d_in;
          end else begin
            base_addr[7:0] <= d_in;
            cur_addr[7:0]  <= d_in;
          end
          byte_ff <= ~byte_ff;
        end else if (a_in == CH_CNT_PORT) begin
          if (byte_ff) begin
            base_cnt[15:8] <= d_in;
            cur_cnt[15:8]  <= d_in;
          end else begin
            base_cnt[7:0] <= d_in;
            cur_cnt[7:0]  <= d_in;
          end
          byte_ff <= ~byte_ff;
        end else if (a_in == CH_PAGE_PORT) begin
          page <= d_in[3:0];
        end else if (a_in == MASK_PORT) begin
          if (d_in[1:0] == CHAN_SEL) mask <= d_in[2];
        end else if (a_in == MODE_PORT) begin
          if (d_in[1:0] == CHAN_SEL) begin
            xfer_type <= d_in[3:2];
`ifdef DMA_AUTOINIT_EN
            autoinit  <= d_in[4];
`else
            autoinit  <= 1'b0;
`endif
          end
        end else if (a_in == CLR_FF_PORT) begin
          byte_ff <= 1'b0;
        end
      end

      // End-of-byte update. Placed last so a terminal count wins over a
      // status read landing on the same clock.
      if (upd) begin
        if (reload) begin
          cur_addr <= base_addr;
          cur_cnt  <= base_cnt;
        end else begin
          cur_addr <= nxt_addr;
          cur_cnt  <= nxt_cnt;
        end
        if (set_tc)   tc_flag <= 1'b1;
        if (set_mask) mask    <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_floppy_channel.sv
// Single-channel 8237-style DMA engine for a floppy controller.
// Purpose: on an unmasked drq, requests the bus (hrq), and after hlda moves
// one byte per request: S1 drives the address and dack_n, S2 holds the
// read/write strobes for WAIT_CYCLES clocks, S3 releases them and steps the
// address up and count down. Count 0000 is the last byte (tc).
// Optional feature: DMA_AUTOINIT_EN (see dma_chan_regs) reloads the current
// address/count from the base copies at terminal count and keeps the channel
// unmasked.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   a_in, d_in, ior_n, iow_n, aen   CPU register access
//   d_out, d_oe                     CPU read data / valid
//   drq, dack_n, tc                 device request / acknowledge / last byte
//   hrq, hlda                       bus hold request / acknowledge
//   a_out, a_oe                     memory address and its enable
//   memr_n, memw_n, dma_ior_n, dma_iow_n   bus strobes
//   dbg_state                       current sequencer state (dma_state_e)
// Handshake: hrq stays high from HOLD through S3; the byte is only started
// after hlda is seen high in HOLD, and hrq drops the clock after S3 (or after
// drq falls while still waiting in HOLD). All bus outputs decode directly
// from the state register, so reset releases them without a clock edge.
module dma_floppy_channel
  import dma_pkg::*;
#(
  parameter logic [19:0] CH_ADDR_PORT = 20'h004,
  parameter logic [19:0] CH_CNT_PORT  = 20'h005,
  parameter logic [19:0] CH_PAGE_PORT = 20'h081,
  parameter int          WAIT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [19:0] a_in,
  input  logic [7:0]  d_in,
  input  logic        ior_n,
  input  logic        iow_n,
  input  logic        aen,
  output logic [7:0]  d_out,
  output logic        d_oe,
  input  logic        drq,
  output logic        dack_n,
  output logic        tc,
  output logic        hrq,
  input  logic        hlda,
  output logic [19:0] a_out,
  output logic        a_oe,
  output logic        memr_n,
  output logic        memw_n,
  output logic        dma_ior_n,
  output logic        dma_iow_n,
  output logic [2:0]  dbg_state
);

  dma_state_e  state;
  dma_state_e  state_nxt;
  logic [3:0]  wait_cnt;
  logic [15:0] cur_addr;
  logic [15:0] cur_cnt;
  logic [3:0]  page;
  logic        mask;
  logic [1:0]  xfer_type;
  logic        autoinit;
  logic        term;
  logic        upd;

  assign term      = (cur_cnt == 16'h0000);
  assign upd       = (state == ST_S3);
  assign a_out     = {page, cur_addr};
  assign dbg_state = state;

  dma_chan_regs #(
    .CH_ADDR_PORT (CH_ADDR_PORT),
    .CH_CNT_PORT  (CH_CNT_PORT),
    .CH_PAGE_PORT (CH_PAGE_PORT)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .d_in      (d_in),
    .ior_n     (ior_n),
    .iow_n     (iow_n),
    .aen       (aen),
    .drq       (drq),
    .busy      (state != ST_IDLE),
    .upd       (upd),
    .reload    (term && autoinit),
    .set_tc    (term),
    .set_mask  (term && !autoinit),
    .nxt_addr  (cur_addr + 16'd1),
    .nxt_cnt   (cur_cnt - 16'd1),
    .d_out     (d_out),
    .d_oe      (d_oe),
    .cur_addr  (cur_addr),
    .cur_cnt   (cur_cnt),
    .page      (page),
    .mask      (mask),
    .xfer_type (xfer_type),
    .autoinit  (autoinit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state <= state_nxt;
      // Loaded in S1 so S2 lasts exactly WAIT_CYCLES clocks.
      if (state == ST_S1)
        wait_cnt <= 4'(WAIT_CYCLES - 1);
      else if (state == ST_S2 && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    hrq       = 1'b1;
    dack_n    = 1'b1;
    a_oe      = 1'b0;
    tc        = 1'b0;
    memr_n    = 1'b1;
    memw_n    = 1'b1;
    dma_ior_n = 1'b1;
    dma_iow_n = 1'b1;
    case (state)
      ST_IDLE: begin
        hrq = 1'b0;
        if (drq && !mask) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (!drq)      state_nxt = ST_IDLE;
        else if (hlda) state_nxt = ST_S1;
      end
      ST_S1: begin
        dack_n    = 1'b0;
        a_oe      = 1'b1;
        state_nxt = ST_S2;
      end
      ST_S2: begin
        dack_n = 1'b0;
        a_oe   = 1'b1;
        tc     = term;
        if (xfer_type == XFER_DEV2MEM) begin
          dma_ior_n = 1'b0;
          memw_n    = 1'b0;
        end else if (xfer_type == XFER_MEM2DEV) begin
          memr_n    = 1'b0;
          dma_iow_n = 1'b0;
        end
        if (wait_cnt == 4'd0) state_nxt = ST_S3;
      end
      ST_S3: begin
        a_oe      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        hrq       = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dma_floppy_channel.sv
// Testbench for dma_floppy_channel: table of fixed transfers, hand-written
// corner sequences, and randomized programming/transfers checked against a
// byte-level model of the channel registers.
`timescale 1ns/1ps
module tb_dma_floppy_channel;

  localparam int W = 2;
`ifdef DMA_AUTOINIT_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif
  localparam logic [19:0] P_ADDR = 20'h004, P_CNT = 20'h005, P_PAGE = 20'h081;
  localparam logic [19:0] P_STAT = 20'h008, P_MASK = 20'h00A, P_MODE = 20'h00B, P_CLR = 20'h00C;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0, rst_n = 1'b0;
  logic [19:0] a_in = '0;
  logic [7:0]  d_in = '0;
  logic ior_n = 1'b1, iow_n = 1'b1, aen = 1'b0, drq = 1'b0, hlda = 1'b0;
  logic [7:0] d_out;
  logic d_oe, dack_n, tc, hrq, a_oe, memr_n, memw_n, dma_ior_n, dma_iow_n;
  logic [19:0] a_out;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  dma_floppy_channel #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .d_in(d_in), .ior_n(ior_n),
    .iow_n(iow_n), .aen(aen), .d_out(d_out), .d_oe(d_oe), .drq(drq),
    .dack_n(dack_n), .tc(tc), .hrq(hrq), .hlda(hlda), .a_out(a_out),
    .a_oe(a_oe), .memr_n(memr_n), .memw_n(memw_n), .dma_ior_n(dma_ior_n),
    .dma_iow_n(dma_iow_n), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_base_addr, m_cur_addr, m_base_cnt, m_cur_cnt;
  logic [3:0]  m_page;
  logic [1:0]  m_type;
  bit          m_mask, m_auto, m_tc_flag;

  task automatic model_reset();
    m_base_addr = 0; m_cur_addr = 0; m_base_cnt = 0; m_cur_cnt = 0;
    m_page = 0; m_type = 0; m_mask = 1; m_auto = 0; m_tc_flag = 0;
  endtask

  // Predicts one drq service and advances the model past it.
  task automatic model_xfer(output bit sv, output logic [19:0] a,
                            output int nw, nr, ni, no, ntc);
    sv = 0; a = '0; nw = 0; nr = 0; ni = 0; no = 0; ntc = 0;
    if (!m_mask) begin
      sv = 1;
      a  = {m_page, m_cur_addr};
      if (m_type == 2'b01) begin nw = W; ni = W; end
      if (m_type == 2'b10) begin nr = W; no = W; end
      if (m_cur_cnt == 0) begin
        ntc = W;
        m_tc_flag = 1;
        if (m_auto) begin
          m_cur_addr = m_base_addr;
          m_cur_cnt  = m_base_cnt;
        end else begin
          m_cur_addr = m_cur_addr + 1;
          m_cur_cnt  = 16'hFFFF;
          m_mask     = 1;
        end
      end else begin
        m_cur_addr = m_cur_addr + 1;
        m_cur_cnt  = m_cur_cnt - 1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic [19:0] addr, input logic [7:0] data);
    a_in = addr; d_in = data; iow_n = 1'b0;
    tick();
    iow_n = 1'b1;
    tick();
  endtask

  task automatic cpu_rd(input logic [19:0] addr, output logic [7:0] data);
    a_in = addr; ior_n = 1'b0;
    tick();
    check("rd_d_oe", d_oe, 1'b1);
    data = d_out;
    ior_n = 1'b1;
    tick();
  endtask

  task automatic rd16(input logic [19:0] port, output logic [15:0] v);
    logic [7:0] lo, hi;
    cpu_wr(P_CLR, 8'h00);
    cpu_rd(port, lo);
    cpu_rd(port, hi);
    v = {hi, lo};
  endtask

  task automatic program_ch(input logic [15:0] addr, input logic [3:0] pg,
                            input logic [15:0] cnt, input logic [1:0] typ, input bit au);
    cpu_wr(P_CLR, 8'h00);
    cpu_wr(P_ADDR, addr[7:0]);
    cpu_wr(P_ADDR, addr[15:8]);
    cpu_wr(P_CNT, cnt[7:0]);
    cpu_wr(P_CNT, cnt[15:8]);
    cpu_wr(P_PAGE, {4'h0, pg});
    cpu_wr(P_MODE, {3'b000, au, typ, 2'b10});
    cpu_wr(P_MASK, 8'h02);
    m_base_addr = addr; m_cur_addr = addr; m_base_cnt = cnt; m_cur_cnt = cnt;
    m_page = pg; m_type = typ; m_auto = au & AUTO_EN; m_mask = 0;
  endtask

  // Raises drq and plays the bus-master side; counts strobe/tc cycles.
  task automatic do_xfer(output bit sv, output logic [19:0] a,
                         output int nw, nr, ni, no, ntc);
    bit got, done;
    sv = 0; a = '0; nw = 0; nr = 0; ni = 0; no = 0; ntc = 0; got = 0; done = 0;
    drq = 1'b1;
    for (int i = 0; i < 8 && !sv; i++) begin
      tick();
      if (hrq) sv = 1;
    end
    if (sv) begin
      hlda = 1'b1; aen = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
        tick();
        if (!dack_n && !got) begin a = a_out; got = 1; drq = 1'b0; end
        if (!memw_n) nw++;
        if (!memr_n) nr++;
        if (!dma_ior_n) ni++;
        if (!dma_iow_n) no++;
        if (tc) ntc++;
        if (!hrq) done = 1;
      end
      hlda = 1'b0; aen = 1'b0;
      if (!done) check("xfer_timeout", 32'd0, 32'd1);
    end
    drq = 1'b0;
    tick();
  endtask

  task automatic xfer_vs(input string name, input bit e_sv, input logic [19:0] e_a,
                         input int e_w, e_r, e_i, e_o, e_tc, output bit sv);
    logic [19:0] a;
    int nw, nr, ni, no, ntc;
    do_xfer(sv, a, nw, nr, ni, no, ntc);
    check({name, ".served"}, sv, e_sv);
    if (e_sv) begin
      check({name, ".a_out"}, a, e_a);
      check({name, ".memw"}, nw, e_w);
      check({name, ".memr"}, nr, e_r);
      check({name, ".ior"}, ni, e_i);
      check({name, ".iow"}, no, e_o);
      check({name, ".tc"}, ntc, e_tc);
    end
  endtask

  task automatic checked_xfer(input string name, output bit sv);
    bit e_sv;
    logic [19:0] e_a;
    int e_w, e_r, e_i, e_o, e_tc;
    model_xfer(e_sv, e_a, e_w, e_r, e_i, e_o, e_tc);
    xfer_vs(name, e_sv, e_a, e_w, e_r, e_i, e_o, e_tc, sv);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] addr; logic [3:0] pg; logic [15:0] cnt; logic [1:0] typ;
    logic [19:0] e_a; int e_w, e_r, e_i, e_o, e_tc;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] v16;
    logic [7:0]  v8;
    bit          sv, dummy_sv, hold_seen, dack_seen;
    logic [19:0] da;
    int          d1, d2, d3, d4, d5;

    tbl[0] = '{16'h1000, 4'h2, 16'h0001, 2'b01, 20'h21000, W, 0, W, 0, 0};
    tbl[1] = '{16'h00FF, 4'hA, 16'h0005, 2'b00, 20'hA00FF, 0, 0, 0, 0, 0};
    tbl[2] = '{16'h8000, 4'h7, 16'h0000, 2'b10, 20'h78000, 0, W, 0, W, W};
    tbl[3] = '{16'h1234, 4'hF, 16'h0000, 2'b01, 20'hF1234, W, 0, W, 0, W};

    model_reset();
    repeat (3) tick();
    // Reset state, while rst_n is still low.
    check("rst_hrq", hrq, 1'b0);
    check("rst_dack_n", dack_n, 1'b1);
    check("rst_tc", tc, 1'b0);
    check("rst_strobes", {memr_n, memw_n, dma_ior_n, dma_iow_n}, 4'hF);
    check("rst_a_oe", a_oe, 1'b0);
    check("rst_d_oe", d_oe, 1'b0);
    rst_n = 1'b1;
    tick();
    rd16(P_ADDR, v16); check("rst_cur_addr", v16, 16'h0000);
    rd16(P_CNT, v16);  check("rst_cur_cnt", v16, 16'h0000);
    cpu_rd(P_STAT, v8); check("rst_status", v8, 8'h00);
    checked_xfer("rst_masked", sv);

    // Table-driven single transfers.
    for (int i = 0; i < 4; i++) begin
      program_ch(tbl[i].addr, tbl[i].pg, tbl[i].cnt, tbl[i].typ, 1'b0);
      model_xfer(dummy_sv, da, d1, d2, d3, d4, d5);
      xfer_vs($sformatf("tbl%0d", i), 1'b1, tbl[i].e_a, tbl[i].e_w, tbl[i].e_r,
              tbl[i].e_i, tbl[i].e_o, tbl[i].e_tc, sv);
    end
    cpu_rd(P_STAT, v8); m_tc_flag = 0;

    // Two-byte block: second byte is terminal.
    program_ch(16'h1000, 4'h2, 16'h0001, 2'b01, 1'b0);
    model_xfer(dummy_sv, da, d1, d2, d3, d4, d5);
    xfer_vs("blk_b0", 1'b1, 20'h21000, W, 0, W, 0, 0, sv);
    model_xfer(dummy_sv, da, d1, d2, d3, d4, d5);
    xfer_vs("blk_b1", 1'b1, 20'h21001, W, 0, W, 0, W, sv);
    cpu_rd(P_STAT, v8); check("blk_status", v8, 8'h04); m_tc_flag = 0;

    // Address wrap at FFFF, page held, mask set at terminal count.
    program_ch(16'hFFFF, 4'h3, 16'h0000, 2'b01, 1'b0);
    model_xfer(dummy_sv, da, d1, d2, d3, d4, d5);
    xfer_vs("wrap", 1'b1, 20'h3FFFF, W, 0, W, 0, W, sv);
    rd16(P_ADDR, v16); check("wrap_cur_addr", v16, 16'h0000);
    rd16(P_CNT, v16);  check("wrap_cur_cnt", v16, 16'hFFFF);
    cpu_rd(P_PAGE, v8); check("wrap_page", v8, 8'h03);
    cpu_rd(P_STAT, v8); check("wrap_status1", v8, 8'h04);
    cpu_rd(P_STAT, v8); check("wrap_status2", v8, 8'h00);
    m_tc_flag = 0;
    xfer_vs("wrap_masked", 1'b0, 20'h0, 0, 0, 0, 0, 0, sv);

    // drq withdrawn before hlda.
    program_ch(16'h4000, 4'h1, 16'h0005, 2'b01, 1'b0);
    drq = 1'b1; hold_seen = 0; dack_seen = 0;
    for (int i = 0; i < 8 && !hold_seen; i++) begin
      tick();
      if (hrq) hold_seen = 1;
      if (!dack_n) dack_seen = 1;
    end
    check("abort_hrq_up", hold_seen, 1'b1);
    drq = 1'b0;
    tick();
    check("abort_hrq_down", hrq, 1'b0);
    if (!dack_n) dack_seen = 1;
    check("abort_no_dack", dack_seen, 1'b0);
    rd16(P_CNT, v16); check("abort_cnt", v16, 16'h0005);

    // Writes with aen=1 or while busy must not land.
    aen = 1'b1; cpu_wr(P_MASK, 8'h06); aen = 1'b0;
    drq = 1'b1;
    for (int i = 0; i < 8 && !hrq; i++) tick();
    cpu_wr(P_MASK, 8'h06);
    cpu_wr(P_PAGE, 8'h0C);
    drq = 1'b0;
    tick();
    checked_xfer("busy_wr", sv);

    // Asynchronous reset during S2 of a memory->device byte.
    program_ch(16'h5000, 4'h6, 16'h0003, 2'b10, 1'b0);
    drq = 1'b1;
    for (int i = 0; i < 8 && !hrq; i++) tick();
    hlda = 1'b1; aen = 1'b1;
    tick();
    tick();
    check("s2_memr_low", memr_n, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_memr_n", memr_n, 1'b1);
    check("arst_iow_n", dma_iow_n, 1'b1);
    check("arst_dack_n", dack_n, 1'b1);
    check("arst_hrq", hrq, 1'b0);
    check("arst_a_oe", a_oe, 1'b0);
    drq = 1'b0; hlda = 1'b0; aen = 1'b0;
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    rd16(P_CNT, v16); check("arst_cnt", v16, 16'h0000);

    // Autoinit at terminal count.
    program_ch(16'h2000, 4'h5, 16'h0000, 2'b01, 1'b1);
    checked_xfer("auto_b0", sv);
    rd16(P_CNT, v16); check("auto_cnt", v16, AUTO_EN ? 16'h0000 : 16'hFFFF);
    checked_xfer("auto_b1", sv);
    check("auto_second_served", sv, AUTO_EN);
    cpu_rd(P_STAT, v8); m_tc_flag = 0;

    // Randomized programming and transfers against the model.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0 || (m_mask && $urandom_range(0, 1) == 1))
        program_ch(16'($urandom), 4'($urandom_range(0, 15)), 16'($urandom_range(0, 3)),
                   2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      checked_xfer($sformatf("rnd%0d", i), sv);
      rd16(P_ADDR, v16); check("rnd_cur_addr", v16, m_cur_addr);
      rd16(P_CNT, v16);  check("rnd_cur_cnt", v16, m_cur_cnt);
      if ($urandom_range(0, 1) == 1) begin
        cpu_rd(P_STAT, v8);
        check("rnd_status", v8, {5'b00000, m_tc_flag, 2'b00});
        m_tc_flag = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dma_floppy_channel.md
DMA_FLOPPY_CHANNEL -- requirements
Module: dma_floppy_channel

Interface
REQ-001 SHALL have parameter CH_ADDR_PORT, default 20'h004, meaning the I/O address of the channel base/current address register.
REQ-002 SHALL have parameter CH_CNT_PORT, default 20'h005, meaning the I/O address of the base/current count register.
REQ-003 SHALL have parameter CH_PAGE_PORT, default 20'h081, meaning the I/O address of the page register (address bits 19:16).
REQ-004 SHALL have parameter WAIT_CYCLES, default 2, range 1..15, meaning the number of clocks strobes stay asserted in S2.
REQ-005 SHALL use one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-006 Ports: clk in 1 system clock; rst_n in 1 async active-low reset.
REQ-007 Ports: a_in in 20 CPU address; d_in in 8 CPU write data; ior_n in 1; iow_n in 1; aen in 1 (1 = DMA owns bus, CPU decode off).
REQ-008 Ports: d_out out 8 register read data; d_oe out 1 d_out valid.
REQ-009 Ports: drq in 1 device request; dack_n out 1 acknowledge; tc out 1 terminal count.
REQ-010 Ports: hrq out 1 bus hold request; hlda in 1 hold acknowledge.
REQ-011 Ports: a_out out 20 memory address; a_oe out 1; memr_n, memw_n, dma_ior_n, dma_iow_n out 1 each, bus strobes.

Function
REQ-012 CPU access SHALL decode only when aen=0: address/count writes load base and current copies, low byte first, selected by a byte-pointer flip-flop that toggles per access; reads return the current value the same way.
REQ-013 Write to 20'h00C SHALL clear the flip-flop; write to 20'h00A with d_in[1:0]=2 SHALL set mask to d_in[2]; write to 20'h00B with d_in[1:0]=2 SHALL load mode: d_in[3:2] type (01 device->memory, 10 memory->device, 00 verify), d_in[4] autoinit.
REQ-014 Read of 20'h008 SHALL return {1'b0, drq, 3'b0, tc_flag, 2'b0} and clear tc_flag after the read.
REQ-015 FSM states IDLE, HOLD, S1, S2, S3.
REQ-016 IDLE->HOLD when drq=1 and mask=0; hrq=1 in HOLD, S1, S2, S3.
REQ-017 HOLD->S1 when hlda=1; HOLD->IDLE, hrq dropped next clock, if drq falls before hlda.
REQ-018 S1 (1 clock): a_out={page, current address}, a_oe=1, dack_n=0.
REQ-019 S2 (WAIT_CYCLES clocks): device->memory asserts dma_ior_n=0, memw_n=0; memory->device asserts memr_n=0, dma_iow_n=0; verify asserts no strobes; tc=1 throughout S2 iff current count=16'h0000.
REQ-020 S3 (1 clock): strobes, dack_n, tc deasserted; address += 1 (16-bit wrap, page unchanged); count -= 1 (0000 wraps to FFFF); ->IDLE, hrq=0 next clock (single-transfer mode, one byte per request).
REQ-021 On a transfer with count=0000 SHALL set tc_flag and set mask unless autoinit is active.
REQ-022 CPU register writes while state≠IDLE SHALL be ignored.
REQ-023 Total transfer is count+1 bytes; latency from hlda to first strobe is exactly 1 clock.

Reset
REQ-024 rst_n=0 SHALL immediately force IDLE, hrq=0, dack_n=1, tc=0, all strobes=1, a_oe=0, d_oe=0, mask=1, flip-flop=0, tc_flag=0, registers=0, mode=verify, also mid-transfer.

Configuration
REQ-025 With DMA_AUTOINIT_EN defined, mode bit 4 SHALL be honoured: after terminal count, current address/count reload from base copies and mask stays 0.
REQ-026 Without DMA_AUTOINIT_EN, mode bit 4 SHALL be stored but ignored and reads back 0.

Structure
REQ-027 Package dma_pkg SHALL hold the FSM state encoding, transfer-type codes and the 20'h008/00A/00B/00C port constants.
REQ-028 The CPU-side register file SHALL be sub-module dma_chan_regs; FSM and address/count update stay in dma_floppy_channel.

Verification
REQ-029 Program addr 16'h1000, page 4'h2, count 16'h0001, mode device->memory, unmask; pulse drq twice -> two transfers at a_out 20'h21000 then 20'h21001, memw_n/dma_ior_n low 2 clocks each, tc=1 only on the second.
REQ-030 Addr 16'hFFFF, page 4'h3, count 0 -> a_out 20'h3FFFF, next current address reads 16'h0000, page remains 3, mask=1, status bit2=1 then 0 on second read.
REQ-031 drq raised then dropped before hlda -> hrq falls next clock, dack_n never asserted, count unchanged.
REQ-032 rst_n low during S2 of a memory->device transfer -> memr_n, dma_iow_n, dack_n go 1 and hrq 0 without a clock edge.
REQ-033 With DMA_AUTOINIT_EN, count 16'h0000, autoinit set -> after transfer current count reads 16'h0000, mask=0, second drq served; without macro -> mask=1, second drq ignored.
